stream_frame_writer: RTL and testbench
======================================

# stream_frame_writer

Terminal sink for the filtered pixel stream produced by the 5x5 window pipeline. Consumes 8-bit pixels qualified by `validin` and flagged by `blanking_in`. Discards blanking pixels and packs active pixels four at a time into 32-bit words. Writes the words to frame-buffer memory through a registered req/ack write port, buffered by a 4-entry FIFO.

## Interface
- `width`, 420: active pixels per line; must be a multiple of 4.
- `height`, 300: active lines per frame.
- `base_addr`, 0: word address of pixel (0,0) in the frame buffer.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `din`  in  8  pixel data; sampled only when `validin`=1.
- `blanking_in`  in  1  pixel is blanking; the pixel is dropped.
- `validin`  in  1  qualifies `din`/`blanking_in` this cycle.
- `wr_req`  out  1  write request; high whenever the FIFO is non-empty.
- `wr_addr`  out  20  word address of the FIFO head.
- `wr_data`  out  32  packed pixels of the FIFO head; the lowest-index pixel is in [7:0].
- `wr_ack`  in  1  memory accepts the head entry this cycle.
- `frame_done`  out  1  one-cycle pulse after the final word of a frame is pushed (or dropped).
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
- Active pixel: `validin`=1 and `blanking_in`=0. All other cycles leave state unchanged.
- Pack register:
  - A 2-bit lane counter selects the byte lane; each active pixel writes `din` into that lane and increments the lane.
  - At lane 3 the completed word `{din, lane2, lane1, lane0}` is pushed into the FIFO with address `base_addr + word_count`, and the lane returns to 0.
- `word_count` (20 bits) increments on every push attempt, dropped or not, so addresses stay frame-aligned.
- Line and frame counting:
  - `x` counts active pixels 0..width-1.
  - `y` counts lines 0..height-1.
  - At x=width-1 and y=height-1: `x`, `y` and `word_count` clear, and a `frame_done` pulse is scheduled for the next cycle.
- FIFO: 4 entries, each 52 bits (addr+data).
  - Pop occurs when `wr_req`&`wr_ack`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; occupancy is unchanged.
  - Push while full without a pop drops the new word and sets `overflow`. The FIFO contents are untouched.
- `wr_ack` while `wr_req`=0 is ignored.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - Outputs: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `overflow`=0.
  - Internal state: lane=0, x=y=word_count=0, FIFO empty.
- Reset mid-operation: any partial word is discarded and all queued entries are lost. `wr_req` is low the cycle after reset is sampled. The next active pixel becomes lane 0 of word `base_addr`.
- Latency: when the 4th pixel of a group is sampled at edge N into an empty FIFO, `wr_req`=1 with that entry valid after edge N.
- `wr_addr`/`wr_data` are stable while `wr_req`=1 and `wr_ack`=0. The head changes only on the edge that samples `wr_ack`=1.
- `frame_done` is high for exactly the cycle after the edge that sampled the last active pixel of the frame.
- Sustained throughput: 1 word per 4 active pixels. The FIFO never overflows if `wr_ack` is asserted at least once in every 4 active-pixel cycles on average. Burst tolerance is 4 words.

## Test plan
- Packing:
  - Stimulus: reset, then 4 active pixels 0x11, 0x22, 0x33, 0x44 with `wr_ack` held 1.
  - Required: the cycle after the 4th pixel shows `wr_req`=1, `wr_addr`=base_addr, `wr_data`=0x44332211. `wr_req` is 0 the following cycle.
- Blanking skip:
  - Stimulus: interleave blanking pixels (value 0xFF) and `validin`=0 gaps between active pixels 0x01..0x04.
  - Required: a single word 0x04030201; no 0xFF byte in any lane.
- Backpressure and overflow:
  - Stimulus: `wr_ack`=0, then 20 active pixels (5 words).
  - Required: `overflow` rises after the 5th word. Then assert `wr_ack`=1; exactly 4 words pop, addresses base+0..base+3.
  - Required: the next word after further input is at base+5, not base+4.
- Full FIFO, simultaneous push/pop:
  - Stimulus: fill 4 entries, then complete a 5th word on the same cycle `wr_ack`=1.
  - Required: no overflow, occupancy stays 4, and the 5th word is delivered last.
- Frame wrap:
  - Stimulus: `width`=8, `height`=2, stream 16 active pixels twice.
  - Required: `frame_done` pulses once per frame, 1 cycle after pixel 16. Second-frame addresses restart at base+0..base+3.
- Reset mid-frame:
  - Stimulus: 6 active pixels, reset for 1 cycle, then 4 pixels 0xA0..0xA3.
  - Required: the only word emitted after reset is addr=base, data 0xA3A2A1A0, with `overflow`=0.

Source files
------------

// File: rtl/stream_frame_writer.sv
// Frame-buffer sink: drops blanking, packs active pixels four per 32-bit word
// and queues {address, data} in a 4-entry FIFO drained through a req/ack port.
module stream_frame_writer #(
   parameter int          width     = 420,
   parameter int          height    = 300,
   parameter logic [19:0] base_addr = 20'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  din,
   input  logic        blanking_in,
   input  logic        validin,
   output logic        wr_req,
   output logic [19:0] wr_addr,
   output logic [31:0] wr_data,
   input  logic        wr_ack,
   output logic        frame_done,
   output logic        overflow
);

   logic [1:0]  lane;
   logic [23:0] pack_reg;
   logic [15:0] x;
   logic [15:0] y;
   logic [19:0] word_count;

   logic [51:0] fifo_mem [0:3];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [2:0]  count;

   logic        active;
   logic        last_x;
   logic        last_y;
   logic        push;
   logic        pop;
   logic        full;
   logic        push_ok;
   logic [51:0] push_entry;

   assign active     = validin && !blanking_in;
   assign last_x     = (x == 16'(width - 1));
   assign last_y     = (y == 16'(height - 1));
   assign push       = active && (lane == 2'd3);
   assign pop        = wr_req && wr_ack;
   assign full       = (count == 3'd4);
   assign push_ok    = push && (!full || pop);
   assign push_entry = {base_addr + word_count, din, pack_reg};

   assign wr_req  = (count != 3'd0);
   assign wr_addr = fifo_mem[rd_ptr][51:32];
   assign wr_data = fifo_mem[rd_ptr][31:0];

   // Packing and raster position; word_count advances on every completed word
   // so a dropped word still consumes its address slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         lane       <= 2'd0;
         pack_reg   <= 24'd0;
         x          <= 16'd0;
         y          <= 16'd0;
         word_count <= 20'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= active && last_x && last_y;
         if (active) begin
            case (lane)
               2'd0:    pack_reg[7:0]   <= din;
               2'd1:    pack_reg[15:8]  <= din;
               2'd2:    pack_reg[23:16] <= din;
               default: ;
            endcase
            lane <= lane + 2'd1;
            if (last_x) begin
               x <= 16'd0;
               if (last_y) begin
                  y          <= 16'd0;
                  word_count <= 20'd0;
               end else begin
                  y          <= y + 16'd1;
                  word_count <= word_count + {19'd0, push};
               end
            end else begin
               x          <= x + 16'd1;
               word_count <= word_count + {19'd0, push};
            end
         end
      end
   end

   // A push into a full FIFO is honoured only when the head pops on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) fifo_mem[i] <= 52'd0;
         rd_ptr   <= 2'd0;
         wr_ptr   <= 2'd0;
         count    <= 3'd0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= push_entry;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'd0, push_ok} - {2'd0, pop};
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_frame_writer.sv
// Directed bench for stream_frame_writer: a large-frame instance for packing and
// FIFO behaviour, and an 8x2 instance for frame wrap.
module tb_stream_frame_writer;

   localparam logic [19:0] BASE_A = 20'h00100;
   localparam logic [19:0] BASE_B = 20'h00040;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  din = 8'd0;
   logic        blanking_in = 1'b0;
   logic        validin = 1'b0;
   logic        wr_ack = 1'b0;

   logic        wr_req_a, frame_done_a, overflow_a;
   logic [19:0] wr_addr_a;
   logic [31:0] wr_data_a;
   logic        wr_req_b, frame_done_b, overflow_b;
   logic [19:0] wr_addr_b;
   logic [31:0] wr_data_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   stream_frame_writer #(.width(420), .height(300), .base_addr(BASE_A)) dut_a (
      .clock(clock), .reset(reset), .din(din), .blanking_in(blanking_in),
      .validin(validin), .wr_req(wr_req_a), .wr_addr(wr_addr_a),
      .wr_data(wr_data_a), .wr_ack(wr_ack), .frame_done(frame_done_a),
      .overflow(overflow_a)
   );

   stream_frame_writer #(.width(8), .height(2), .base_addr(BASE_B)) dut_b (
      .clock(clock), .reset(reset), .din(din), .blanking_in(blanking_in),
      .validin(validin), .wr_req(wr_req_b), .wr_addr(wr_addr_b),
      .wr_data(wr_data_b), .wr_ack(wr_ack), .frame_done(frame_done_b),
      .overflow(overflow_b)
   );

   task automatic applyStimulus(input logic v, input logic b, input logic [7:0] d);
      validin     = v;
      blanking_in = b;
      din         = d;
      @(posedge clock);
      #1;
      validin     = 1'b0;
      blanking_in = 1'b0;
   endtask

   task automatic pixel(input logic [7:0] d);
      applyStimulus(1'b1, 1'b0, d);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic doReset();
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expWord(input logic [7:0] b, input int k);
      logic [7:0] p;
      p = b + 8'(4 * k);
      return {p + 8'd3, p + 8'd2, p + 8'd1, p};
   endfunction

   initial begin
      // Packing
      wr_ack = 1'b1;
      doReset();
      checkOutput("reset_wr_req", {31'd0, wr_req_a}, 32'd0);
      checkOutput("reset_wr_addr", {12'd0, wr_addr_a}, 32'd0);
      checkOutput("reset_wr_data", wr_data_a, 32'd0);
      checkOutput("reset_frame_done", {31'd0, frame_done_a}, 32'd0);
      checkOutput("reset_overflow", {31'd0, overflow_a}, 32'd0);
      pixel(8'h11); pixel(8'h22); pixel(8'h33);
      checkOutput("pack_no_req_early", {31'd0, wr_req_a}, 32'd0);
      pixel(8'h44);
      checkOutput("pack_wr_req", {31'd0, wr_req_a}, 32'd1);
      checkOutput("pack_wr_addr", {12'd0, wr_addr_a}, {12'd0, BASE_A});
      checkOutput("pack_wr_data", wr_data_a, 32'h44332211);
      idle();
      checkOutput("pack_req_drops", {31'd0, wr_req_a}, 32'd0);

      // Blanking skip
      wr_ack = 1'b0;
      doReset();
      applyStimulus(1'b1, 1'b1, 8'hFF);
      pixel(8'h01);
      applyStimulus(1'b0, 1'b0, 8'hFF);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      pixel(8'h02);
      applyStimulus(1'b0, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      pixel(8'h03);
      applyStimulus(1'b0, 1'b0, 8'hFF);
      pixel(8'h04);
      checkOutput("blank_wr_req", {31'd0, wr_req_a}, 32'd1);
      checkOutput("blank_wr_data", wr_data_a, 32'h04030201);
      checkOutput("blank_wr_addr", {12'd0, wr_addr_a}, {12'd0, BASE_A});
      wr_ack = 1'b1;
      idle();
      checkOutput("blank_single_word", {31'd0, wr_req_a}, 32'd0);

      // Backpressure and overflow
      wr_ack = 1'b0;
      doReset();
      for (int i = 0; i < 16; i++) pixel(8'(i));
      checkOutput("bp_no_overflow_4", {31'd0, overflow_a}, 32'd0);
      for (int i = 16; i < 20; i++) pixel(8'(i));
      checkOutput("bp_overflow_5", {31'd0, overflow_a}, 32'd1);
      wr_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("bp_req_%0d", k), {31'd0, wr_req_a}, 32'd1);
         checkOutput($sformatf("bp_addr_%0d", k), {12'd0, wr_addr_a}, {12'd0, BASE_A + 20'(k)});
         checkOutput($sformatf("bp_data_%0d", k), wr_data_a, expWord(8'h00, k));
         idle();
      end
      checkOutput("bp_drained", {31'd0, wr_req_a}, 32'd0);
      for (int i = 0; i < 4; i++) pixel(8'h50 + 8'(i));
      checkOutput("bp_next_req", {31'd0, wr_req_a}, 32'd1);
      checkOutput("bp_next_addr", {12'd0, wr_addr_a}, {12'd0, BASE_A + 20'd5});
      checkOutput("bp_next_data", wr_data_a, expWord(8'h50, 0));
      checkOutput("bp_overflow_sticky", {31'd0, overflow_a}, 32'd1);

      // Full FIFO with simultaneous push and pop
      wr_ack = 1'b0;
      doReset();
      for (int i = 0; i < 19; i++) pixel(8'h40 + 8'(i));
      wr_ack = 1'b1;
      pixel(8'h40 + 8'd19);
      checkOutput("full_no_overflow", {31'd0, overflow_a}, 32'd0);
      for (int k = 1; k < 5; k++) begin
         checkOutput($sformatf("full_req_%0d", k), {31'd0, wr_req_a}, 32'd1);
         checkOutput($sformatf("full_addr_%0d", k), {12'd0, wr_addr_a}, {12'd0, BASE_A + 20'(k)});
         checkOutput($sformatf("full_data_%0d", k), wr_data_a, expWord(8'h40, k));
         idle();
      end
      checkOutput("full_drained", {31'd0, wr_req_a}, 32'd0);

      // Frame wrap on the 8x2 instance
      wr_ack = 1'b1;
      doReset();
      for (int i = 0; i < 32; i++) begin
         pixel(8'h80 + 8'(i));
         checkOutput($sformatf("wrap_frame_done_%0d", i), {31'd0, frame_done_b},
                     {31'd0, (i % 16) == 15});
         if ((i % 4) == 3) begin
            checkOutput($sformatf("wrap_req_%0d", i), {31'd0, wr_req_b}, 32'd1);
            checkOutput($sformatf("wrap_addr_%0d", i), {12'd0, wr_addr_b},
                        {12'd0, BASE_B + 20'((i % 16) / 4)});
         end
      end
      idle();
      checkOutput("wrap_pulse_ends", {31'd0, frame_done_b}, 32'd0);

      // Reset mid-frame
      wr_ack = 1'b0;
      doReset();
      for (int i = 0; i < 6; i++) pixel(8'h60 + 8'(i));
      checkOutput("mid_pre_req", {31'd0, wr_req_a}, 32'd1);
      reset = 1'b1;
      idle();
      checkOutput("mid_reset_req", {31'd0, wr_req_a}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) pixel(8'hA0 + 8'(i));
      checkOutput("mid_no_partial", {31'd0, wr_req_a}, 32'd0);
      pixel(8'hA3);
      checkOutput("mid_req", {31'd0, wr_req_a}, 32'd1);
      checkOutput("mid_addr", {12'd0, wr_addr_a}, {12'd0, BASE_A});
      checkOutput("mid_data", wr_data_a, 32'hA3A2A1A0);
      checkOutput("mid_overflow", {31'd0, overflow_a}, 32'd0);
      wr_ack = 1'b1;
      idle();
      checkOutput("mid_only_word", {31'd0, wr_req_a}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
